// File: rtl/joybus_pkg.sv
// Shared joybus timing constants and receiver state encoding.
package joybus_pkg;

  localparam int unsigned CYC_PER_US_DEF = 25;
  localparam int unsigned MAX_LOW_US_DEF = 8;
  localparam int unsigned IDLE_US_DEF    = 8;

  // Low-time classification thresholds in clk cycles: <=T1 is a 1, <=T0 is a stop.
  function automatic int unsigned t1_cyc(input int unsigned cyc);
    return (3 * cyc) / 2;
  endfunction

  function automatic int unsigned t0_cyc(input int unsigned cyc);
    return (5 * cyc) / 2;
  endfunction

  localparam int unsigned T1_DEF       = (3 * CYC_PER_US_DEF) / 2;
  localparam int unsigned T0_DEF       = (5 * CYC_PER_US_DEF) / 2;
  localparam int unsigned LOW_MAX_DEF  = MAX_LOW_US_DEF * CYC_PER_US_DEF;
  localparam int unsigned IDLE_MAX_DEF = IDLE_US_DEF * CYC_PER_US_DEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_FAULT
  } rx_state_t;

endpackage

// File: rtl/joybus_sync.sv
// Two-flop line synchronizer with registered rise/fall strobes aligned to the synced value.
module joybus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic line,
  output logic rise,
  output logic fall
);

  logic meta;

  // Strobes are computed from the stage feeding line so they coincide with its transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      line <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= din;
      line <= meta;
      rise <= meta & ~line;
      fall <= ~meta & line;
    end
  end

endmodule

// File: rtl/joybus_rx.sv
// Joybus frame receiver: pulse-width decodes bits, assembles bytes, flags truncated/faulty frames.
module joybus_rx
  import joybus_pkg::*;
#(
  parameter int unsigned CYC_PER_US = CYC_PER_US_DEF,
  parameter int unsigned MAX_LOW_US = MAX_LOW_US_DEF,
  parameter int unsigned IDLE_US    = IDLE_US_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       JB_RX,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       rx_done,
  output logic       rx_err,
  output logic [5:0] rx_cnt
);

  localparam int unsigned T1       = t1_cyc(CYC_PER_US);
  localparam int unsigned T0       = t0_cyc(CYC_PER_US);
  localparam int unsigned LOW_MAX  = MAX_LOW_US * CYC_PER_US;
  localparam int unsigned IDLE_MAX = IDLE_US * CYC_PER_US;
  localparam int unsigned CNT_MAX  = (LOW_MAX > IDLE_MAX) ? LOW_MAX : IDLE_MAX;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);

  logic      line;
  logic      rise;
  logic      fall;
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          is_one;
  logic          is_stop;
  logic [7:0]    next_byte;

  joybus_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (JB_RX),
    .line  (line),
    .rise  (rise),
    .fall  (fall)
  );

  assign is_one    = (cnt <= CW'(T1));
  assign is_stop   = !is_one && (cnt <= CW'(T0));
  assign next_byte = {shreg[6:0], is_one};

  // cnt holds the number of samples seen in the current low or high phase, including the first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rx_data <= '0;
      rx_rdy  <= 1'b0;
      rx_done <= 1'b0;
      rx_err  <= 1'b0;
      rx_cnt  <= '0;
    end else begin
      rx_rdy  <= 1'b0;
      rx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fall && rx_en) begin
            state   <= ST_LOW;
            cnt     <= CW'(1);
            bit_cnt <= '0;
            rx_cnt  <= '0;
            rx_err  <= 1'b0;
          end
        end
        ST_LOW: begin
          if (rise) begin
            if (is_stop) begin
              rx_done <= 1'b1;
              rx_err  <= (bit_cnt != 3'd0);
              state   <= ST_IDLE;
            end else begin
              shreg <= next_byte;
              state <= ST_HIGH;
              cnt   <= CW'(1);
              if (bit_cnt == 3'd7) begin
                rx_data <= next_byte;
                rx_rdy  <= 1'b1;
                bit_cnt <= '0;
                if (rx_cnt != 6'd63) rx_cnt <= rx_cnt + 6'd1;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end else if (cnt == CW'(LOW_MAX)) begin
            state <= ST_FAULT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state <= ST_LOW;
            cnt   <= CW'(1);
          end else if (cnt == CW'(IDLE_MAX)) begin
            rx_done <= 1'b1;
            rx_err  <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_FAULT: begin
          if (line) begin
            rx_done <= 1'b1;
            rx_err  <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_joybus_rx.sv
// Scoreboard bench for joybus_rx: expected strobes queued with stimulus, checked as they appear.
module tb_joybus_rx;

  logic       clk;
  logic       rst_n;
  logic       JB_RX;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rx_done;
  logic       rx_err;
  logic [5:0] rx_cnt;

  typedef struct {
    bit         is_done;
    logic [7:0] data;
    logic       err;
    logic [5:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;
  int   strobes;

  joybus_rx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .JB_RX   (JB_RX),
    .rx_en   (rx_en),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .rx_done (rx_done),
    .rx_err  (rx_err),
    .rx_cnt  (rx_cnt)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic observe();
    exp_t e;
    if (rst_n) begin
      if (rx_rdy && rx_done) begin
        total++;
        bad++;
        $display("FAIL strobe_overlap rdy=%0b done=%0b required not both", rx_rdy, rx_done);
      end
      if (rx_rdy || rx_done) begin
        strobes++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe rdy=%0b done=%0b data=%02h", rx_rdy, rx_done, rx_data);
        end else begin
          e = exp_q.pop_front();
          if (rx_rdy) begin
            if (e.is_done || rx_data !== e.data) begin
              bad++;
              $display("FAIL rdy_data got=%02h want=%02h want_done=%0b", rx_data, e.data, e.is_done);
            end
          end else if (!e.is_done || rx_err !== e.err || rx_cnt !== e.cnt) begin
            bad++;
            $display("FAIL done_status got err=%0b cnt=%0d want err=%0b cnt=%0d want_done=%0b",
                     rx_err, rx_cnt, e.err, e.cnt, e.is_done);
          end
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      observe();
    end
  endtask

  task automatic drive(input int low, input int high);
    JB_RX = 1'b0;
    tick(low);
    JB_RX = 1'b1;
    tick(high);
  endtask

  task automatic send_bit(input logic b);
    if (b) drive(25, 75);
    else   drive(75, 25);
  endtask

  task automatic expect_rdy(input logic [7:0] d);
    exp_t e;
    e.is_done = 1'b0; e.data = d; e.err = 1'b0; e.cnt = '0;
    exp_q.push_back(e);
  endtask

  task automatic expect_done(input logic err, input logic [5:0] cnt);
    exp_t e;
    e.is_done = 1'b1; e.data = '0; e.err = err; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] v);
    expect_rdy(v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_strobes pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    JB_RX = 1'b1;
    rx_en = 1'b0;
    tick(3);
    total++;
    if (rx_data !== 8'h00 || rx_rdy !== 1'b0 || rx_done !== 1'b0 || rx_err !== 1'b0 || rx_cnt !== 6'd0) begin
      bad++;
      $display("FAIL reset_values data=%02h rdy=%0b done=%0b err=%0b cnt=%0d required all 0",
               rx_data, rx_rdy, rx_done, rx_err, rx_cnt);
    end
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_reply();
    rx_en = 1'b1;
    send_byte(8'h05);
    rx_en = 1'b0;
    send_byte(8'h00);
    send_byte(8'h02);
    expect_done(1'b0, 6'd3);
    drive(50, 100);
    check_drained("reply");
    total++;
    if (rx_data !== 8'h02 || rx_cnt !== 6'd3 || rx_err !== 1'b0) begin
      bad++;
      $display("FAIL reply_hold data=%02h cnt=%0d err=%0b required 02/3/0", rx_data, rx_cnt, rx_err);
    end
  endtask

  task automatic test_thresholds();
    rx_en = 1'b1;
    expect_rdy(8'h01);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    drive(37, 63);
    expect_done(1'b0, 6'd1);
    drive(38, 100);
    check_drained("thr_37_38");
    expect_rdy(8'hFE);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    drive(63, 37);
    expect_done(1'b0, 6'd1);
    drive(62, 100);
    check_drained("thr_62_63");
    total++;
    if (rx_data !== 8'hFE) begin
      bad++;
      $display("FAIL thr_data got=%02h want=fe", rx_data);
    end
  endtask

  task automatic test_truncated();
    logic [4:0] pat;
    pat = 5'b10110;
    rx_en = 1'b1;
    expect_done(1'b1, 6'd0);
    for (int i = 4; i >= 0; i--) send_bit(pat[i]);
    drive(50, 100);
    check_drained("trunc_stop");
    total++;
    if (rx_err !== 1'b1 || rx_cnt !== 6'd0) begin
      bad++;
      $display("FAIL trunc_stop_status err=%0b cnt=%0d want 1/0", rx_err, rx_cnt);
    end
    send_byte(8'h5A);
    expect_done(1'b1, 6'd1);
    tick(250);
    check_drained("trunc_idle");
    total++;
    if (rx_err !== 1'b1 || rx_cnt !== 6'd1 || rx_data !== 8'h5A) begin
      bad++;
      $display("FAIL trunc_idle_status err=%0b cnt=%0d data=%02h want 1/1/5a", rx_err, rx_cnt, rx_data);
    end
  endtask

  task automatic test_stuck_low();
    rx_en = 1'b1;
    expect_done(1'b1, 6'd0);
    JB_RX = 1'b0;
    tick(300);
    JB_RX = 1'b1;
    tick(2);
    total++;
    if (rx_done !== 1'b0) begin
      bad++;
      $display("FAIL stuck_early_done got=%0b want=0", rx_done);
    end
    tick(1);
    total++;
    if (rx_done !== 1'b1 || rx_err !== 1'b1) begin
      bad++;
      $display("FAIL stuck_done_timing done=%0b err=%0b want 1/1", rx_done, rx_err);
    end
    tick(20);
    check_drained("stuck");
  endtask

  task automatic test_arming();
    int s;
    rx_en = 1'b0;
    s = strobes;
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    drive(50, 100);
    drive(300, 50);
    tick(250);
    total++;
    if (strobes != s || rx_err !== 1'b1) begin
      bad++;
      $display("FAIL arming_ignored strobes=%0d err=%0b want %0d/1", strobes - s, rx_err, 0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int s;
    logic [3:0] part;
    part = 4'b0011;
    rx_en = 1'b1;
    send_byte(8'hA5);
    for (int i = 3; i >= 0; i--) send_bit(part[i]);
    JB_RX = 1'b0;
    tick(10);
    rst_n = 1'b0;
    tick(3);
    total++;
    if (rx_data !== 8'h00 || rx_cnt !== 6'd0 || rx_err !== 1'b0 || rx_rdy !== 1'b0 || rx_done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_values data=%02h cnt=%0d err=%0b rdy=%0b done=%0b want 0",
               rx_data, rx_cnt, rx_err, rx_rdy, rx_done);
    end
    JB_RX = 1'b1;
    tick(2);
    rst_n = 1'b1;
    s = strobes;
    tick(300);
    total++;
    if (strobes != s) begin
      bad++;
      $display("FAIL midreset_quiet strobes=%0d want=0", strobes - s);
    end
    send_byte(8'h80);
    expect_done(1'b0, 6'd1);
    drive(50, 100);
    check_drained("clean_frame");
    total++;
    if (rx_data !== 8'h80 || rx_cnt !== 6'd1 || rx_err !== 1'b0) begin
      bad++;
      $display("FAIL clean_frame_status data=%02h cnt=%0d err=%0b want 80/1/0", rx_data, rx_cnt, rx_err);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    strobes = 0;
    rst_n   = 1'b0;
    JB_RX   = 1'b1;
    rx_en   = 1'b0;
    test_reset();
    test_reply();
    test_thresholds();
    test_truncated();
    test_stuck_low();
    test_arming();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
